vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates the raster pixel coordinates (x, y), sync pulses and blanking for the VGA display path.
- It is the producer end of the pixel-coordinate interface; the symbol/shape renderers consume x, y combinationally and return "pixel inside shape" flags.
- Runs from the 50 MHz system clock using a pixel-enable tick, not a derived clock. Default timing is 640x480 @ 60 Hz.

Parameters:
- CLK_DIV, 2, system clocks per pixel; legal values 1..16.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; when 0, counters and outputs freeze
- pix_tick  out  1  one-clk pulse per pixel; renderers sample on this
- x  out  10  horizontal count, 0..H_TOTAL-1
- y  out  10  vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- video_on  out  1  1 when x<H_ACTIVE and y<V_ACTIVE
- line_start  out  1  one-clk pulse coincident with the pix_tick at which x becomes 0
- frame_start  out  1  one-clk pulse coincident with the pix_tick at which x=0 and y=0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; enforced by an elaboration-time check.
- Reset values (async, immediate): x=0, y=0, video_on=0, pix_tick=0, line_start=0, frame_start=0, hsync=vsync=!SYNC_POL (inactive). Divider count = 0.
- Pixel tick: the divider counts 0..CLK_DIV-1 while en=1. pix_tick is asserted for one clk when the count wraps.
  - CLK_DIV=1 gives pix_tick=1 on every enabled clock.
  - First pix_tick occurs CLK_DIV clks after reset release with en=1.
- Counter advance (on the pix_tick cycle only):
  - x increments.
  - At x=H_TOTAL-1, x wraps to 0 and y increments.
  - At y=V_TOTAL-1 with x wrapping, y wraps to 0.
- Horizontal phase FSM, advanced on pix_tick:
  - States: H_ACT, H_FRONT, H_SYNC_S, H_BACK.
  - H_ACT→H_FRONT at x=H_ACTIVE; H_FRONT→H_SYNC_S at H_ACTIVE+H_FP; H_SYNC_S→H_BACK at H_ACTIVE+H_FP+H_SYNC; H_BACK→H_ACT at the wrap.
  - Vertical FSM is identical (V_ACT, V_FRONT, V_SYNC_S, V_BACK), advanced only on line wrap.
- All outputs are registered and consistent with the current x, y (zero relative latency):
  - hsync active iff H FSM = H_SYNC_S, i.e. x in [656, 751].
  - vsync active iff V FSM = V_SYNC_S, i.e. y in [490, 491].
  - video_on = (H FSM = H_ACT) && (V FSM = V_ACT).
- en=0: the divider holds, pix_tick=0 and all counters/FSMs hold. On en returning to 1, counting resumes with no skipped or repeated pixel.
- Reset mid-frame returns everything to the reset state immediately. The first frame after reset starts at x=0, y=0, but frame_start is not pulsed for it; frame_start first pulses at the next wrap to (0,0).
- Illegal FSM encodings recover to H_ACT/V_ACT on the next pix_tick.

Decomposition:
- Package vga_pkg holds:
  - default timing localparams (640x480@60);
  - typedef enum h_phase_t {H_ACT, H_FRONT, H_SYNC_S, H_BACK};
  - typedef enum v_phase_t {V_ACT, V_FRONT, V_SYNC_S, V_BACK};
  - typedef logic [9:0] coord_t, shared with the shape renderers.
- One sub-module, pixel_tick_gen: parameterized by CLK_DIV, with inputs clk, rst_n, en and output tick.
- Counters and both FSMs live in vga_timing_gen.

Test Plan:
- Reset, then en=1 with CLK_DIV=2 → first pix_tick at clk 2. x steps 0,1,2 every 2 clks; hsync=vsync=1 and video_on=1 at x<640, y=0.
- Run one line → hsync low for exactly 96 pix_ticks (x 656..751, i.e. 192 clks). x wraps 799→0 with y 0→1 and line_start pulsed; line period is 1600 clks.
- Run a full frame → vsync low for y=490..491 (1600 pix_ticks). video_on=0 for y≥480. frame_start pulses once after 420000 pix_ticks (840000 clks), with x=y=0.
- Deassert en for 37 clks at x=300 → x, y, sync and video_on hold, with no pix_tick. After re-enable, the next pix_tick gives x=301.
- Assert rst_n=0 asynchronously mid-frame at y=250, x=700 (no clk edge) → outputs go to the reset values immediately. After release, counting restarts from 0,0 and frame_start is not pulsed at restart.
- CLK_DIV=1 build → pix_tick stuck at 1 while enabled; line = 800 clks, frame = 420000 clks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 timing, raster phase
// enumerations and the coordinate type used by the shape renderers.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC_S, H_BACK} h_phase_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC_S, V_BACK} v_phase_t;

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Pixel-enable divider: counts 0..CLK_DIV-1 while en=1.
// Ports: clk, rst_n (async active-low), en (run enable),
//        tick (combinational strobe, high on the enabled clock where the count wraps).
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("pixel_tick_gen: CLK_DIV must be in 1..16");
  end

  logic [CW-1:0] cnt;

  // Divider count; holds while disabled so no pixel is skipped or repeated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Strobe is combinational so the top can register it alongside x/y.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel coordinates, sync pulses and blanking.
// Ports: clk, rst_n (async active-low), en (run enable);
//        pix_tick (one clk per pixel), x/y (raster position),
//        hsync/vsync (polarity SYNC_POL), video_on (visible area),
//        line_start / frame_start (pulse with the pix_tick that wraps to x=0 / (0,0)).
// All outputs are registered and updated together, so sync/blank always
// describe the x, y currently presented.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end

  // Phase boundaries: the coordinate at which each phase begins.
  localparam coord_t H_FP_X   = coord_t'(H_ACTIVE);
  localparam coord_t H_SYNC_X = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_BP_X   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_FP_Y   = coord_t'(V_ACTIVE);
  localparam coord_t V_SYNC_Y = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_BP_Y   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);

  logic     tick;
  h_phase_t h_state, h_next;
  v_phase_t v_state, v_next;
  coord_t   x_nxt, y_nxt;
  logic     x_wrap, y_wrap;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  // Next raster position.
  always_comb begin
    x_wrap = (x == H_LAST);
    y_wrap = (y == V_LAST);
    x_nxt  = x_wrap ? '0 : x + coord_t'(1);
    y_nxt  = y;
    if (x_wrap) begin
      y_nxt = y_wrap ? '0 : y + coord_t'(1);
    end
  end

  // Phase state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_state <= H_ACT;
      v_state <= V_ACT;
    end else begin
      h_state <= h_next;
      v_state <= v_next;
    end
  end

  // Horizontal phase, keyed on the coordinate being entered.
  always_comb begin
    h_next = h_state;
    if (tick) begin
      case (h_state)
        H_ACT:    if (x_nxt == H_FP_X)   h_next = H_FRONT;
        H_FRONT:  if (x_nxt == H_SYNC_X) h_next = H_SYNC_S;
        H_SYNC_S: if (x_nxt == H_BP_X)   h_next = H_BACK;
        H_BACK:   if (x_wrap)            h_next = H_ACT;
        default:                         h_next = H_ACT;
      endcase
    end
  end

  // Vertical phase; y only changes on a line wrap.
  always_comb begin
    v_next = v_state;
    if (tick) begin
      case (v_state)
        V_ACT:    if (x_wrap && y_nxt == V_FP_Y)   v_next = V_FRONT;
        V_FRONT:  if (x_wrap && y_nxt == V_SYNC_Y) v_next = V_SYNC_S;
        V_SYNC_S: if (x_wrap && y_nxt == V_BP_Y)   v_next = V_BACK;
        V_BACK:   if (x_wrap && y_wrap)            v_next = V_ACT;
        default:                                   v_next = V_ACT;
      endcase
    end
  end

  // Registered outputs, derived from the next phase so they match the new x, y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_tick    <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick;
      line_start  <= tick && x_wrap;
      frame_start <= tick && x_wrap && y_wrap;
      if (tick) begin
        x        <= x_nxt;
        y        <= y_nxt;
        hsync    <= (h_next == H_SYNC_S) ? SYNC_POL : ~SYNC_POL;
        vsync    <= (v_next == V_SYNC_S) ? SYNC_POL : ~SYNC_POL;
        video_on <= (h_next == H_ACT) && (v_next == V_ACT);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a reduced raster (25 x 11) so full frames
// fit in a short run; a CLK_DIV=2 active-low instance and a CLK_DIV=1
// active-high instance share the same stimulus.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 25
  localparam int VT = VA + VF + VS + VB;   // 11

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic       pt0, hs0, vs0, vo0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       pt1, hs1, vs1, vo1, ls1, fs1;
  logic [9:0] x1, y1;

  int vectors = 0;
  int miscompares = 0;

  // Model state: enabled clock edges since reset and en at the last edge.
  int ec = 0;
  bit le = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(pt0), .x(x0), .y(y0),
    .hsync(hs0), .vsync(vs0), .video_on(vo0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(pt1), .x(x1), .y(y1),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .line_start(ls1), .frame_start(fs1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs from the pixel count: n pixels elapsed since reset.
  task automatic expv(input int e, input bit l, input int d, input bit pol,
                      output int ex, output int ey, output bit et, output bit ehs,
                      output bit evs, output bit evo, output bit els, output bit efs);
    int n;
    n   = e / d;
    ex  = n % HT;
    ey  = (n / HT) % VT;
    et  = l && (e > 0) && (e % d == 0);
    ehs = (ex >= HA + HF && ex < HA + HF + HS) ? pol : ~pol;
    evs = (ey >= VA + VF && ey < VA + VF + VS) ? pol : ~pol;
    evo = (n > 0) && (ex < HA) && (ey < VA);
    els = et && (ex == 0);
    efs = els && (ey == 0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ec <= 0;
      le <= 1'b0;
    end else begin
      le <= en;
      if (en) ec <= ec + 1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int ex, ey;
    bit et, ehs, evs, evo, els, efs;
    expv(ec, le, 2, 1'b0, ex, ey, et, ehs, evs, evo, els, efs);
    chk("d0_pix_tick", pt0, et);   chk("d0_x", x0, ex);       chk("d0_y", y0, ey);
    chk("d0_hsync", hs0, ehs);     chk("d0_vsync", vs0, evs); chk("d0_video_on", vo0, evo);
    chk("d0_line_start", ls0, els); chk("d0_frame_start", fs0, efs);
    expv(ec, le, 1, 1'b1, ex, ey, et, ehs, evs, evo, els, efs);
    chk("d1_pix_tick", pt1, et);   chk("d1_x", x1, ex);       chk("d1_y", y1, ey);
    chk("d1_hsync", hs1, ehs);     chk("d1_vsync", vs1, evs); chk("d1_video_on", vo1, evo);
    chk("d1_line_start", ls1, els); chk("d1_frame_start", fs1, efs);
  end

  // kind 0: dut0 pix_tick at (tx,ty); 1: frame_start; 2: line_start; 3: any pix_tick.
  task automatic wait_ev(input int kind, input int tx, input int ty, input int budget,
                         output int clks, output int hs_low, output int vs_low);
    bit hit;
    clks = 0; hs_low = 0; vs_low = 0; hit = 1'b0;
    while (!hit && clks < budget) begin
      @(negedge clk);
      clks++;
      if (pt0 && !hs0) hs_low++;
      if (pt0 && !vs0) vs_low++;
      case (kind)
        0: hit = pt0 && (x0 == 10'(tx)) && (y0 == 10'(ty));
        1: hit = fs0;
        2: hit = ls0;
        default: hit = pt0;
      endcase
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_kind%0d: timeout after %0d clks, required event within %0d", kind, clks, budget);
    end
  endtask

  initial begin
    int clks, hsl, vsl, ticks;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", x0, 0); chk("rst_hsync", hs0, 1); chk("rst_video_on", vo0, 0);
    chk("rst_d1_hsync", hs1, 0);

    // Release with en=1; dut0 ticks on the 2nd edge, dut1 on every edge.
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    chk("edge1_pix_tick", pt0, 0); chk("edge1_x", x0, 0);
    chk("edge1_d1_pix_tick", pt1, 1); chk("edge1_d1_x", x1, 1);
    @(negedge clk);
    chk("edge2_pix_tick", pt0, 1); chk("edge2_x", x0, 1); chk("edge2_video_on", vo0, 1);
    chk("edge2_hsync", hs0, 1); chk("edge2_d1_x", x1, 2);

    // First frame_start only after a full frame: 275 pixels = 550 clks.
    wait_ev(1, 0, 0, 700, clks, hsl, vsl);
    chk("first_frame_clks", ec, 550);
    chk("first_frame_x", x0, 0); chk("first_frame_y", y0, 0);
    chk("d1_frame_start_at_550", fs1, 1);

    // One line: 50 clks, hsync low on 3 pixels.
    wait_ev(2, 0, 0, 100, clks, hsl, vsl);
    chk("line_clks", clks, 50); chk("line_hsync_low", hsl, 3); chk("line_y", y0, 1);

    // Rest of the frame: vsync low for 2 lines = 50 pixels.
    wait_ev(1, 0, 0, 700, clks, hsl, vsl);
    chk("frame_rest_clks", clks, 500); chk("frame_vsync_low", vsl, 50);

    // Freeze at x=10 for 37 clks, then resume at x=11.
    wait_ev(0, 10, 0, 100, clks, hsl, vsl);
    en = 1'b0;
    ticks = 0;
    repeat (37) begin
      @(negedge clk);
      if (pt0) ticks++;
    end
    chk("hold_ticks", ticks, 0); chk("hold_x", x0, 10); chk("hold_video_on", vo0, 1);
    en = 1'b1;
    wait_ev(3, 0, 0, 5, clks, hsl, vsl);
    chk("resume_x", x0, 11); chk("resume_clks", clks, 2);

    // Async reset mid-frame at (20,5), between clock edges.
    wait_ev(0, 20, 5, 700, clks, hsl, vsl);
    chk("pre_reset_hsync", hs0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_x", x0, 0); chk("async_y", y0, 0); chk("async_hsync", hs0, 1);
    chk("async_video_on", vo0, 0); chk("async_pix_tick", pt0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ev(1, 0, 0, 700, clks, hsl, vsl);
    chk("restart_frame_clks", clks, 550);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
